// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: buffers commands in a FIFO, drives the ALU one
// command at a time, waits out its latency and returns results over valid/ready.
//
// state  | meaning
// S_IDLE | no command in the ALU; pop the FIFO head when one is queued
// S_WAIT | operands applied; down-counting the ALU latency, capture at zero
// S_HOLD | result presented on rsp_*; held until the consumer accepts it
module alu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_select,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic [SEL_W-1:0] rsp_sel,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam int ENT_W = 2 * WIDTH + SEL_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  logic [ENT_W-1:0] fifo_mem [DEPTH];

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [SEL_W-1:0] rsp_sel_q, rsp_sel_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             push, pop;
  logic [WIDTH-1:0] head_a, head_b;
  logic [SEL_W-1:0] head_sel;

  assign push = cmd_valid && cmd_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);
  assign {head_sel, head_b, head_a} = fifo_mem[rd_ptr_q];

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_sel, cmd_b, cmd_a};
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    tmr_d       = tmr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_valid_d = rsp_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    // Registered full flag; a pop in the same cycle frees space only next cycle.
    cmd_ready_d = (count_d != CNT_W'(DEPTH));

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          alu_a_d   = head_a;
          alu_b_d   = head_b;
          alu_sel_d = head_sel;
          rsp_sel_d = head_sel;
          tmr_d     = TMR_W'(ALU_LAT);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry;
          rsp_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      tmr_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      tmr_q       <= tmr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_sel    = rsp_sel_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a registered 1-cycle ALU model
// (0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A).
module tb_alu_cmd_sequencer;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_select;
  logic       alu_carry;
  logic       rsp_valid, rsp_ready, rsp_carry, busy;
  logic [7:0] rsp_data;
  logic [3:0] rsp_sel;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] alu_res;
  always_comb begin
    alu_res = {1'b0, alu_a};
    case (alu_select)
      4'd0:    alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2:    alu_res = {1'b0, alu_a & alu_b};
      4'd3:    alu_res = {1'b0, alu_a | alu_b};
      4'd4:    alu_res = {1'b0, alu_a ^ alu_b};
      default: alu_res = {1'b0, alu_a};
    endcase
  end
  always @(posedge clk) begin
    alu_out   <= alu_res[7:0];
    alu_carry <= alu_res[8];
  end

  typedef struct {
    logic [7:0] a, b, data;
    logic [3:0] sel;
    logic       carry;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks hold stability.
  logic       pv, pr, pc;
  logic [7:0] pd;
  logic [3:0] ps;
  initial begin pv = 0; pr = 0; pc = 0; pd = 0; ps = 0; end
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0; pr = 0;
    end else begin
      if (pv && !pr && rsp_valid) begin
        chk("hold_data_stable", rsp_data, pd);
        chk("hold_carry_stable", rsp_carry, pc);
        chk("hold_sel_stable", rsp_sel, ps);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got data %0d sel %0d expected no response", rsp_data, rsp_sel);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_carry", rsp_carry, e.carry);
          chk("rsp_sel", rsp_sel, e.sel);
          chk("alu_a_held", alu_a, e.a);
          chk("alu_b_held", alu_b, e.b);
          chk("alu_select_held", alu_select, e.sel);
        end
      end
      pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pc = rsp_carry; ps = rsp_sel;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [7:0] exp_d, input logic exp_c, input bit track);
    bit done;
    exp_t e;
    done = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (track) begin
          e.a = a; e.b = b; e.sel = sel; e.data = exp_d; e.carry = exp_c;
          sb.push_back(e);
        end
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int i;
    i = 0;
    while (sb.size() != 0 && i < bound) begin
      @(posedge clk); i++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  bit bp_on = 0;
  int lat, acc;
  logic [7:0] fa [5] = '{8'd7, 8'd57, 8'd107, 8'd157, 8'd207};
  logic [7:0] fb [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd60};
  logic [7:0] fe [5] = '{8'd8, 8'd59, 8'd110, 8'd161, 8'd11};
  logic       fc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] sw [15] = '{8'd50, 8'd10, 8'd20, 8'd30, 8'd10, 8'd30, 8'd30, 8'd30,
                          8'd30, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30};
  logic [7:0] ba [6] = '{8'd100, 8'd50, 8'd255, 8'd12, 8'd12, 8'd12};
  logic [7:0] bb [6] = '{8'd50, 8'd100, 8'd1, 8'd10, 8'd10, 8'd10};
  logic [3:0] bs [6] = '{4'd1, 4'd1, 4'd0, 4'd2, 4'd3, 4'd4};
  logic [7:0] be [6] = '{8'd50, 8'd206, 8'd0, 8'd8, 8'd14, 8'd6};
  logic       bc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0; rsp_ready = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    #1 chk("cmd_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Reset while the command is waiting on the ALU.
    rsp_ready = 1;
    send(8'd30, 8'd20, 4'd0, 8'd50, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pop_alu_a", alu_a, 30);
    chk("pop_busy", busy, 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_select", alu_select, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rsp_carry", rsp_carry, 0);
    chk("midrst_rsp_sel", rsp_sel, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_cmd_ready_release", cmd_ready, 1);

    // Single command and its latency from acceptance.
    send(8'd30, 8'd20, 4'd0, 8'd50, 1'b0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) lat = k;
    end
    chk("rsp_latency", lat, 3);
    wait_drain(50);

    send(8'd200, 8'd100, 4'd0, 8'd44, 1'b1, 1'b1);
    wait_drain(50);

    // Fill with the consumer stalled.
    rsp_ready = 0;
    acc = 0;
    cmd_valid = 1; cmd_a = fa[0]; cmd_b = fb[0]; cmd_sel = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (acc < 5) begin
          exp_t e;
          e.a = fa[acc]; e.b = fb[acc]; e.sel = 4'd0; e.data = fe[acc]; e.carry = fc[acc];
          sb.push_back(e);
        end
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 5) begin cmd_a = fa[acc]; cmd_b = fb[acc]; end
    end
    cmd_valid = 0;
    chk("fill_accepted", acc, 5);
    @(negedge clk);
    chk("fill_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1;
    wait_drain(100);

    // Opcode sweep, back to back.
    for (int s = 0; s < 15; s++)
      send(8'd30, 8'd20, 4'(s), sw[s], 1'b0, 1'b1);
    wait_drain(200);

    // Random backpressure on the response port.
    bp_on = 1;
    fork
      while (bp_on) begin
        @(posedge clk); #1;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int t = 0; t < 6; t++)
      send(ba[t], bb[t], bs[t], be[t], bc[t], 1'b1);
    wait_drain(500);
    bp_on = 0;
    repeat (2) @(posedge clk);
    #2 rsp_ready = 1;
    @(posedge clk); #1;
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
